// File: rtl/collector_pkg.sv
// rtl/collector_pkg.sv - shared types and helpers for the output event collector
//
// Contents:
//   id_w()         width of a stream index for a given stream count (min 1)
//   drain_state_t  drain FSM states
//   snapshot_t     snapshot record layout for the default configuration
//                  (7 streams x 64 bits), timestamp field only with
//                  COLLECTOR_TIMESTAMP_EN
package collector_pkg;

    localparam int NUM_STREAMS_DEF = 7;
    localparam int DATA_W_DEF      = 64;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } drain_state_t;

    typedef struct packed {
`ifdef COLLECTOR_TIMESTAMP_EN
        logic [31:0]                              stamp;
`endif
        logic [NUM_STREAMS_DEF-1:0]               mask;
        logic [NUM_STREAMS_DEF*DATA_W_DEF-1:0]    values;
    } snapshot_t;

endpackage

// File: rtl/snapshot_fifo.sv
// rtl/snapshot_fifo.sv - synchronous snapshot FIFO with occupancy count
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, push_data   write request and payload
//   pop               read request (removes head_data)
//   head_data         oldest entry, valid when !empty
//   count             number of stored entries (0..DEPTH)
//   full, empty       occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module snapshot_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/output_event_collector.sv
// rtl/output_event_collector.sv - captures monitor output activation sets and drains them serially
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   en                capture enable (drain side runs regardless)
//   out_value         NUM_STREAMS x DATA_W flattened stream values
//   out_aktv          per-stream activation flags
//   rd_valid/rd_ready serial element handshake
//   rd_id, rd_value   stream index and raw value of the current element
//   rd_last           current element is the last active stream of its snapshot
//   collector_ready   at least two FIFO slots free
//   overflow          sticky, a snapshot was dropped
//   drop_count        saturating count of dropped snapshots
//   rd_time           capture cycle of the current snapshot (COLLECTOR_TIMESTAMP_EN only)
// Optional feature macro: COLLECTOR_TIMESTAMP_EN
module output_event_collector
    import collector_pkg::*;
#(
    parameter int NUM_STREAMS = 7,
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    localparam int ID_W       = id_w(NUM_STREAMS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_STREAMS*DATA_W-1:0] out_value,
    input  logic [NUM_STREAMS-1:0]        out_aktv,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [ID_W-1:0]               rd_id,
    output logic [DATA_W-1:0]             rd_value,
    output logic                          rd_last,
    output logic                          collector_ready,
    output logic                          overflow,
    output logic [CNT_W-1:0]              drop_count
`ifdef COLLECTOR_TIMESTAMP_EN
    ,
    output logic [31:0]                   rd_time
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
`ifdef COLLECTOR_TIMESTAMP_EN
        logic [31:0]                   stamp;
`endif
        logic [NUM_STREAMS-1:0]        mask;
        logic [NUM_STREAMS*DATA_W-1:0] values;
    } snap_t;

    snap_t                  push_snap;
    snap_t                  head_snap;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   capture;
    logic                   pop;
    logic                   drop;
    logic                   scanning;
    logic                   one_left;
    drain_state_t           state;
    logic [NUM_STREAMS-1:0] done_mask;
    logic [NUM_STREAMS-1:0] work_mask;
    logic [NUM_STREAMS-1:0] sel_bit;
    logic [ID_W-1:0]        sel_id;

`ifdef COLLECTOR_TIMESTAMP_EN
    logic [31:0] stamp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stamp <= '0;
        else      stamp <= stamp + 32'd1;
    end
`endif

    always_comb begin
        push_snap        = '0;
        push_snap.mask   = out_aktv;
        push_snap.values = out_value;
`ifdef COLLECTOR_TIMESTAMP_EN
        push_snap.stamp  = stamp;
`endif
    end

    assign capture = en && (|out_aktv);

    snapshot_fifo #(
        .WIDTH ($bits(snap_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (push_snap),
        .pop       (pop),
        .head_data (head_snap),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The working mask is the head snapshot's mask minus the streams already
    // handed out; clearing done_mask is what "loads" the next snapshot, so a
    // pop followed by a new head needs no extra copy of the mask.
    assign work_mask = head_snap.mask & ~done_mask;
    assign sel_bit   = work_mask & (~work_mask + NUM_STREAMS'(1));
    assign one_left  = (work_mask != '0) &&
                       ((work_mask & (work_mask - NUM_STREAMS'(1))) == '0);

    always_comb begin
        sel_id = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (work_mask[i]) sel_id = ID_W'(i);
        end
    end

    assign scanning        = (state == SCAN);
    assign rd_valid        = scanning;
    assign rd_id           = scanning ? sel_id : '0;
    assign rd_value        = scanning ? head_snap.values[int'(sel_id)*DATA_W +: DATA_W] : '0;
    assign rd_last         = scanning && one_left;
`ifdef COLLECTOR_TIMESTAMP_EN
    assign rd_time         = scanning ? head_snap.stamp : '0;
`endif
    assign pop             = scanning && rd_ready && one_left;
    assign drop            = capture && fifo_full && !pop;
    assign collector_ready = (fifo_count <= CW'(DEPTH - 2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            done_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_mask <= '0;
                    if (!fifo_empty) state <= SCAN;
                end
                SCAN: begin
                    if (rd_ready) begin
                        if (one_left) begin
                            done_mask <= '0;
                            // Another snapshot behind the head: keep scanning
                            // so it follows without an idle cycle.
                            if (fifo_count < CW'(2)) state <= IDLE;
                        end else begin
                            done_mask <= done_mask | sel_bit;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_output_event_collector.sv
// tb/tb_output_event_collector.sv - self-checking bench for output_event_collector
module tb_output_event_collector;

    logic           clk;
    logic           rst;
    logic           en;
    logic [447:0]   out_value;
    logic [6:0]     out_aktv;
    logic           rd_valid;
    logic           rd_ready;
    logic [2:0]     rd_id;
    logic [63:0]    rd_value;
    logic           rd_last;
    logic           collector_ready;
    logic           overflow;
    logic [15:0]    drop_count;
`ifdef COLLECTOR_TIMESTAMP_EN
    logic [31:0]    rd_time;
`endif

    int checks   = 0;
    int failures = 0;

    output_event_collector dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .out_value       (out_value),
        .out_aktv        (out_aktv),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .rd_id           (rd_id),
        .rd_value        (rd_value),
        .rd_last         (rd_last),
        .collector_ready (collector_ready),
        .overflow        (overflow),
        .drop_count      (drop_count)
`ifdef COLLECTOR_TIMESTAMP_EN
        ,
        .rd_time         (rd_time)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [6:0]  aktv;
        logic [63:0] base;
        logic [63:0] step;
        logic        rdy;
        logic        exp_valid;
        logic [2:0]  exp_id;
        logic [63:0] exp_value;
        logic        exp_last;
        logic        exp_cready;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic e, input logic [6:0] a, input logic [63:0] b,
                                input logic [63:0] s, input logic r, input logic ev,
                                input logic [2:0] eid, input logic [63:0] evl,
                                input logic el, input logic ec);
        vec_t v;
        v.en = e; v.aktv = a; v.base = b; v.step = s; v.rdy = r;
        v.exp_valid = ev; v.exp_id = eid; v.exp_value = evl; v.exp_last = el; v.exp_cready = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Stream k carries base + step*k.
    task automatic set_in(input logic e, input logic [6:0] a, input logic [63:0] b, input logic [63:0] s);
        en       = e;
        out_aktv = a;
        for (int k = 0; k < 7; k++) out_value[k*64 +: 64] = b + s * 64'(k);
    endtask

    // Waits (bounded) for an element, checks it, then lets it be accepted.
    task automatic expect_elem(input string name, input logic [2:0] id, input logic [63:0] val,
                               input logic last);
        for (int n = 0; n < 20 && !rd_valid; n++) begin
            @(posedge clk); #1;
        end
        check({name, "_valid"}, 64'(rd_valid), 64'd1);
        check({name, "_id"},    64'(rd_id),    64'(id));
        check({name, "_value"}, rd_value,      val);
        check({name, "_last"},  64'(rd_last),  64'(last));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        //                 en aktv   base                    step  rdy  v  id value                   last cr
        vecs[0]  = mk(1, 7'h05, 64'd10,                  64'd10, 1, 0, 0, 64'd0,                  0, 1);
        vecs[1]  = mk(1, 7'h00, 64'd0,                   64'd0,  1, 1, 0, 64'd10,                 0, 1);
        vecs[2]  = mk(1, 7'h00, 64'd0,                   64'd0,  1, 1, 2, 64'd30,                 1, 1);
        vecs[3]  = mk(1, 7'h00, 64'd0,                   64'd0,  1, 0, 0, 64'd0,                  0, 1);
        vecs[4]  = mk(1, 7'h05, 64'd10,                  64'd10, 0, 0, 0, 64'd0,                  0, 1);
        vecs[5]  = mk(1, 7'h00, 64'd0,                   64'd0,  0, 1, 0, 64'd10,                 0, 1);
        vecs[6]  = mk(1, 7'h00, 64'd0,                   64'd0,  0, 1, 0, 64'd10,                 0, 1);
        vecs[7]  = mk(1, 7'h00, 64'd0,                   64'd0,  0, 1, 0, 64'd10,                 0, 1);
        vecs[8]  = mk(1, 7'h00, 64'd0,                   64'd0,  0, 1, 0, 64'd10,                 0, 1);
        vecs[9]  = mk(1, 7'h00, 64'd0,                   64'd0,  0, 1, 0, 64'd10,                 0, 1);
        vecs[10] = mk(1, 7'h00, 64'd0,                   64'd0,  1, 1, 2, 64'd30,                 1, 1);
        vecs[11] = mk(1, 7'h00, 64'd0,                   64'd0,  1, 0, 0, 64'd0,                  0, 1);
        vecs[12] = mk(1, 7'h7F, 64'd1,                   64'd1,  1, 0, 0, 64'd0,                  0, 1);
        vecs[13] = mk(1, 7'h01, 64'd8,                   64'd1,  1, 1, 0, 64'd1,                  0, 1);
        vecs[14] = mk(1, 7'h00, 64'd0,                   64'd0,  1, 1, 1, 64'd2,                  0, 1);
        vecs[15] = mk(1, 7'h00, 64'd0,                   64'd0,  1, 1, 2, 64'd3,                  0, 1);
        vecs[16] = mk(1, 7'h00, 64'd0,                   64'd0,  1, 1, 3, 64'd4,                  0, 1);
        vecs[17] = mk(1, 7'h00, 64'd0,                   64'd0,  1, 1, 4, 64'd5,                  0, 1);
        vecs[18] = mk(1, 7'h00, 64'd0,                   64'd0,  1, 1, 5, 64'd6,                  0, 1);
        vecs[19] = mk(1, 7'h00, 64'd0,                   64'd0,  1, 1, 6, 64'd7,                  1, 1);
        vecs[20] = mk(1, 7'h00, 64'd0,                   64'd0,  1, 1, 0, 64'd8,                  1, 1);
        vecs[21] = mk(1, 7'h00, 64'd0,                   64'd0,  1, 0, 0, 64'd0,                  0, 1);
        vecs[22] = mk(1, 7'h40, 64'h8000_0000_0000_0000, 64'd1,  1, 0, 0, 64'd0,                  0, 1);
        vecs[23] = mk(0, 7'h7F, 64'd5,                   64'd5,  1, 1, 6, 64'h8000_0000_0000_0006, 1, 1);
        vecs[24] = mk(1, 7'h00, 64'd0,                   64'd0,  1, 0, 0, 64'd0,                  0, 1);
        vecs[25] = mk(1, 7'h00, 64'd0,                   64'd0,  1, 0, 0, 64'd0,                  0, 1);
        vecs[26] = mk(1, 7'h00, 64'd0,                   64'd0,  1, 0, 0, 64'd0,                  0, 1);

        rst      = 1'b0;
        rd_ready = 1'b0;
        set_in(0, 7'h00, 64'd0, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        check("rst_valid",  64'(rd_valid),        64'd0);
        check("rst_id",     64'(rd_id),           64'd0);
        check("rst_value",  rd_value,             64'd0);
        check("rst_last",   64'(rd_last),         64'd0);
        check("rst_ovf",    64'(overflow),        64'd0);
        check("rst_drops",  64'(drop_count),      64'd0);
        check("rst_cready", 64'(collector_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].en, vecs[i].aktv, vecs[i].base, vecs[i].step);
            rd_ready = vecs[i].rdy;
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_id", i),    64'(rd_id),   64'(vecs[i].exp_id));
                check($sformatf("vec%0d_value", i), rd_value,     vecs[i].exp_value);
                check($sformatf("vec%0d_last", i),  64'(rd_last), 64'(vecs[i].exp_last));
            end
            check($sformatf("vec%0d_cready", i), 64'(collector_ready), 64'(vecs[i].exp_cready));
            @(negedge clk);
        end

        // Overflow: ten single-stream captures with the consumer stalled.
        rd_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            set_in(1, 7'h01, 64'(k), 64'd0);
            @(posedge clk); #1;
            check($sformatf("ovf_cap%0d_cready", k), 64'(collector_ready), (k < 7) ? 64'd1 : 64'd0);
            check($sformatf("ovf_cap%0d_flag", k),   64'(overflow),        (k > 8) ? 64'd1 : 64'd0);
            @(negedge clk);
        end
        set_in(1, 7'h00, 64'd0, 64'd0);
        @(posedge clk); #1;
        check("ovf_drops",   64'(drop_count), 64'd2);
        check("ovf_head_id", 64'(rd_id),      64'd0);
        check("ovf_head_v",  rd_value,        64'd1);
        check("ovf_head_l",  64'(rd_last),    64'd1);

        // Full FIFO: capture on the same edge the head snapshot is accepted.
        @(negedge clk);
        set_in(1, 7'h01, 64'd100, 64'd0);
        rd_ready = 1'b1;
        @(posedge clk); #1;
        set_in(1, 7'h00, 64'd0, 64'd0);
        check("fullpop_drops",  64'(drop_count),      64'd2);
        check("fullpop_cready", 64'(collector_ready), 64'd0);
        for (int k = 2; k <= 8; k++) expect_elem($sformatf("fullpop_e%0d", k), 3'd0, 64'(k), 1'b1);
        expect_elem("fullpop_e100", 3'd0, 64'd100, 1'b1);
        check("fullpop_idle",   64'(rd_valid),        64'd0);
        check("fullpop_cready2", 64'(collector_ready), 64'd1);

        // Reset in the middle of a drain.
        set_in(1, 7'h05, 64'd10, 64'd10);
        rd_ready = 1'b0;
        @(posedge clk); #1;
        set_in(1, 7'h00, 64'd0, 64'd0);
        @(posedge clk); #1;
        check("mid_valid_before", 64'(rd_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rd_valid),   64'd0);
        check("mid_rst_id",    64'(rd_id),      64'd0);
        check("mid_rst_value", rd_value,        64'd0);
        check("mid_rst_last",  64'(rd_last),    64'd0);
        check("mid_rst_ovf",   64'(overflow),   64'd0);
        check("mid_rst_drops", 64'(drop_count), 64'd0);
        @(negedge clk);
        rst      = 1'b1;
        rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst%0d_valid", k),  64'(rd_valid),        64'd0);
            check($sformatf("post_rst%0d_cready", k), 64'(collector_ready), 64'd1);
        end
        @(negedge clk);
        set_in(1, 7'h02, 64'd50, 64'd1);
        @(posedge clk); #1;
        set_in(1, 7'h00, 64'd0, 64'd0);
        check("post_cap_idle", 64'(rd_valid), 64'd0);
        @(posedge clk); #1;
        check("post_cap_valid", 64'(rd_valid), 64'd1);
        check("post_cap_id",    64'(rd_id),    64'd1);
        check("post_cap_value", rd_value,      64'd51);
        check("post_cap_last",  64'(rd_last),  64'd1);
`ifdef COLLECTOR_TIMESTAMP_EN
        check("post_cap_time",  64'(rd_time),  64'd3);
`endif
        @(posedge clk); #1;
        check("post_cap_done", 64'(rd_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_event_collector.md
Name: output_event_collector

Overview:
- Receiving end of the monitor output interface: samples the monitor's output streams (value + aktv flag per stream) every enabled cycle.
- Buffers each non-empty activation set as one snapshot.
- Drains snapshots as a serial (stream_id, value) sequence under valid/ready, for a checker, UART bridge or host readout.
- Asserts collector_ready so upstream can hold new_input when buffering is near exhaustion.

Parameters:
- NUM_STREAMS, 7, number of monitor output streams (a..g).
- DATA_W, 64, width of each signed stream value.
- DEPTH, 8, snapshot FIFO depth; power of two, >= 2.
- CNT_W, 16, width of drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; no capture when low, drain side unaffected.
- out_value  in  NUM_STREAMS*DATA_W  flattened stream values; stream i at bits [i*DATA_W +: DATA_W].
- out_aktv  in  NUM_STREAMS  per-stream activation flags, same cycle as values.
- rd_valid  out  1  serial element available.
- rd_ready  in  1  consumer accepts element.
- rd_id  out  clog2(NUM_STREAMS)  stream index of current element.
- rd_value  out  DATA_W  signed value of current element.
- rd_last  out  1  current element is the last active stream of its snapshot.
- collector_ready  out  1  high when at least 2 FIFO slots are free.
- overflow  out  1  sticky; a snapshot was dropped.
- drop_count  out  CNT_W  number of dropped snapshots, saturating.

Behaviour:
- Reset (rst low, async): FIFO empty, state IDLE, rd_valid=0, rd_id=0, rd_value=0, rd_last=0, overflow=0, drop_count=0. collector_ready=1 after release. Reset mid-drain discards all content.
- Capture: on a clk edge with en=1 and |out_aktv, push {out_aktv, out_value}. Cycles with out_aktv==0 are never stored.
- Full FIFO, no pop in the same cycle: snapshot dropped, overflow set, drop_count +1, saturating at all-ones.
- Full FIFO with a pop in the same cycle: push accepted, nothing dropped.
- Drain FSM:
  - IDLE: on FIFO non-empty, load the head snapshot's mask into the working mask -> SCAN.
  - SCAN: rd_valid=1; rd_id = lowest set bit of working mask; rd_value = that stream's value; rd_last = exactly one bit left.
  - On rd_valid&&rd_ready, clear that bit. If it was the last bit: pop the FIFO; if another snapshot is present, load it in the same cycle and stay in SCAN (back-to-back, no bubble); otherwise -> IDLE.
- Latency: a snapshot captured at edge N into an empty collector gives rd_valid=1 after edge N+1.
- rd_id/rd_value/rd_last stay stable while rd_valid=1 and rd_ready=0.
- Arithmetic: rd_value is passed through bit-exact; no sign extension or modification.
- collector_ready is combinational from the FIFO count: high when count <= DEPTH-2.

Optional Feature:
- Macro: COLLECTOR_TIMESTAMP_EN.
- Defined:
  - Free-running 32-bit cycle counter, cleared by reset, wraps modulo 2^32.
  - Counter value at capture is stored in each snapshot.
  - Extra output rd_time[31:0] presents it, constant across all elements of the snapshot.
- Undefined: no counter, no rd_time port, no extra storage.

Decomposition:
- Package collector_pkg:
  - ID_W = clog2(NUM_STREAMS) helper function.
  - drain state enum {IDLE, SCAN}.
  - snapshot record typedef (mask, values, optional timestamp).
- Sub-module snapshot_fifo: synchronous FIFO with count output and simultaneous push/pop when full.
- Lowest-set-bit priority logic stays inline.

Test Plan:
- Single capture: out_aktv=7'b0000101, a=10, c=30, rd_ready=1 -> elements (0,10,last=0) then (2,30,last=1); rd_valid rises one cycle after capture.
- Back-pressure: same snapshot with rd_ready=0 for 5 cycles -> element (0,10) held stable; release -> (0,10), (2,30) in consecutive cycles.
- Back-to-back: aktv=7'h7F with values 1..7, next cycle aktv=7'h01 with a=8, rd_ready=1 -> ids 0..6 with values 1..7, then (0,8) with no idle cycle; rd_last only on ids 6 and 0.
- Overflow: DEPTH=8, rd_ready=0, 10 captures -> first 8 kept, overflow=1, drop_count=2; collector_ready low from the 7th capture.
- Full plus simultaneous pop: FIFO full, capture on the cycle the last element of the head is accepted -> no drop, count stays 8.
- Reset mid-drain: assert rst during SCAN -> rd_valid=0 immediately; after release FIFO empty, overflow=0; with COLLECTOR_TIMESTAMP_EN, first capture 3 cycles after release shows rd_time=3.
